// File: rtl/sw_debouncer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sw_debouncer_pkg
//  Description : Shared constants and helpers for the switch debouncer.
//                Holds the default width and timing values and the
//                prescaler width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sw_debouncer_pkg;

    localparam int SW_WIDTH         = 6;
    localparam int SYNC_STAGES_DEF  = 2;
    localparam int TICK_DIV_DEF     = 1000;
    localparam int STABLE_TICKS_DEF = 500;

    // Width of a counter that runs 0..n-1. A value of n=1 would give a
    // zero-width counter, so the result never drops below one bit.
    function automatic int tick_cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : sw_debouncer_pkg
`default_nettype wire

// File: rtl/sw_debouncer_debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_bit
//  Description : One switch bit's debounce counter and stable flop. The
//                counter only advances on prescaler ticks while the
//                synchronised input disagrees with the stable value; any
//                agreement clears it. The stable value changes once the
//                disagreement has lasted STABLE_TICKS ticks.
//  Ports       : clock       - system clock
//                reset       - asynchronous active-low reset
//                sync_in     - synchronised switch bit
//                tick        - shared prescaler tick
//                stable_out  - registered debounced bit
//                stable_next - next-state of stable_out, used by the top to
//                              raise its change strobe in the same cycle the
//                              new value becomes visible
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit #(
    parameter int STABLE_TICKS = 500
) (
    input  logic clock,
    input  logic reset,
    input  logic sync_in,
    input  logic tick,
    output logic stable_out,
    output logic stable_next
);

    localparam int                 c_cnt_w    = $clog2(STABLE_TICKS + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STABLE_TICKS - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_stable;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic               w_stable_next;

    always_comb begin
        w_cnt_next    = r_cnt;
        w_stable_next = r_stable;
        if (sync_in == r_stable) begin
            // Agreement throws away any partial progress.
            w_cnt_next = '0;
        end else if (tick) begin
            if (r_cnt == c_cnt_last) begin
                w_stable_next = sync_in;
                w_cnt_next    = '0;
            end else begin
                w_cnt_next = r_cnt + c_cnt_w'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_stable <= w_stable_next;
        end
    end

    assign stable_out  = r_stable;
    assign stable_next = w_stable_next;

endmodule : debounce_bit
`default_nettype wire

// File: rtl/sw_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : sw_debouncer
//  Description : Conditions raw board switches for the RGB controller.
//                Each bit is synchronised through a flop chain, then
//                debounced against a free-running shared tick prescaler.
//                Produces a registered switch word and a one-cycle strobe
//                in the cycle that word changes.
//  Ports       : clock      - system clock (100 MHz)
//                reset      - asynchronous active-low reset
//                sw_raw     - asynchronous switch pins
//                sw_out     - debounced switch word (to rgb_controller SW)
//                sw_changed - one-cycle pulse when sw_out takes a new value
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_debouncer
    import sw_debouncer_pkg::*;
#(
    parameter int WIDTH        = SW_WIDTH,
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic             sw_changed
);

    // ------------------------------------------------------------------
    // Synchroniser: plain flop chain, nothing between stages.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_sync;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= sw_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Prescaler: free-running, never restarted by switch activity, so
    // every bit sees the same tick phase.
    // ------------------------------------------------------------------
    logic w_tick;

    if (TICK_DIV == 1) begin : g_tick_always
        assign w_tick = 1'b1;
    end else begin : g_tick_presc
        localparam int                   c_presc_w    = tick_cnt_width(TICK_DIV);
        localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(TICK_DIV - 1);

        logic [c_presc_w-1:0] r_presc;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_presc <= '0;
            end else if (r_presc == c_presc_last) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + c_presc_w'(1);
            end
        end

        assign w_tick = (r_presc == c_presc_last);
    end

    // ------------------------------------------------------------------
    // Per-bit debounce.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_stable_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_debounce_bit (
            .clock       (clock),
            .reset       (reset),
            .sync_in     (w_sync[i]),
            .tick        (w_tick),
            .stable_out  (w_stable[i]),
            .stable_next (w_stable_next[i])
        );
    end

    // ------------------------------------------------------------------
    // Change strobe: registered from the next-state so it rises together
    // with the new sw_out; simultaneous commits merge into one pulse.
    // ------------------------------------------------------------------
    logic r_changed;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= |(w_stable_next ^ w_stable);
        end
    end

    assign sw_out     = w_stable;
    assign sw_changed = r_changed;

endmodule : sw_debouncer
`default_nettype wire

// File: tb/tb_sw_debouncer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sw_debouncer
//  Description : Scoreboard bench for sw_debouncer with TICK_DIV=4,
//                STABLE_TICKS=3, SYNC_STAGES=2. Stimulus pushes the
//                expected new switch word and its arrival window; a
//                monitor pops on every sw_changed strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_debouncer;

    localparam int W = 6;

    // With TICK_DIV=4 and STABLE_TICKS=3 a commit lands 9..12 cycles after
    // the synchronised input first differs; the 2-stage synchroniser adds 2.
    localparam int LAT_LO = 11;
    localparam int LAT_HI = 14;

    typedef struct {
        logic [W-1:0] val;
        int           lo;
        int           hi;
    } exp_t;

    logic         clock;
    logic         reset;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_out;
    logic         sw_changed;

    int           cyc;
    int           n_vec;
    int           n_fail;
    exp_t         sb_q[$];
    logic [W-1:0] prev_out;

    sw_debouncer #(
        .WIDTH        (W),
        .SYNC_STAGES  (2),
        .TICK_DIV     (4),
        .STABLE_TICKS (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sw_raw     (sw_raw),
        .sw_out     (sw_out),
        .sw_changed (sw_changed)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            if (sw_changed) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: cycle %0d sw_out=%b, required no strobe", cyc, sw_out);
                end else begin
                    e = sb_q.pop_front();
                    n_vec++;
                    if (sw_out !== e.val) begin
                        n_fail++;
                        $display("FAIL commit_value: cycle %0d sw_out=%b, required %b", cyc, sw_out, e.val);
                    end
                    n_vec++;
                    if (cyc < e.lo || cyc > e.hi) begin
                        n_fail++;
                        $display("FAIL commit_time: strobe at cycle %0d, required %0d..%0d", cyc, e.lo, e.hi);
                    end
                end
            end else if (sb_q.size() != 0 && cyc > sb_q[0].hi) begin
                e = sb_q.pop_front();
                n_vec++;
                n_fail++;
                $display("FAIL commit_timeout: no strobe by cycle %0d, required %b by %0d", cyc, e.val, e.hi);
            end
            if (sw_out !== prev_out) begin
                n_vec++;
                if (sw_changed !== 1'b1) begin
                    n_fail++;
                    $display("FAIL strobe_missing: sw_out %b->%b with sw_changed=%b, required 1", prev_out, sw_out, sw_changed);
                end
            end
        end else begin
            n_vec++;
            if (sw_out !== '0) begin
                n_fail++;
                $display("FAIL reset_out: sw_out=%b, required 000000", sw_out);
            end
            n_vec++;
            if (sw_changed !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_strobe: sw_changed=%b, required 0", sw_changed);
            end
        end
        prev_out = sw_out;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic apply(input logic [W-1:0] v, input logic [W-1:0] expv, input bit has_exp);
        exp_t e;
        @(posedge clock);
        #1;
        sw_raw = v;
        if (has_exp) begin
            e.val = expv;
            e.lo  = cyc + LAT_LO;
            e.hi  = cyc + LAT_HI;
            sb_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic check_out(input string name, input logic [W-1:0] req);
        @(negedge clock);
        n_vec++;
        if (sw_out !== req) begin
            n_fail++;
            $display("FAIL %s: sw_out=%b, required %b", name, sw_out, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        cyc      = 0;
        n_vec    = 0;
        n_fail   = 0;
        prev_out = '0;
        reset    = 1'b1;
        sw_raw   = 6'b111111;
        #1 reset = 1'b0;

        // 1. Reset with all switches on, then commit after release.
        idle(3);
        #1;
        reset = 1'b1;
        e.val = 6'b111111;
        e.lo  = cyc + LAT_LO;
        e.hi  = cyc + LAT_HI;
        sb_q.push_back(e);
        idle(20);

        // 2. Clean step on bit 0 from a stable zero word.
        apply(6'b000000, 6'b000000, 1'b1);
        idle(20);
        apply(6'b000001, 6'b000001, 1'b1);
        idle(20);

        // 3. Bit 3 bounces every 5 cycles for 60 cycles, then settles high.
        for (int k = 0; k < 12; k++) begin
            apply(sw_raw ^ 6'b001000, 6'b000000, 1'b0);
            idle(4);
        end
        check_out("bounce_hold", 6'b000001);
        apply(6'b001001, 6'b001001, 1'b1);
        idle(20);

        // 4. Three bits change on the same cycle: one strobe.
        apply(6'b000001, 6'b000001, 1'b1);
        idle(20);
        apply(6'b110000, 6'b110000, 1'b1);
        idle(20);

        // 5. Reset in the middle of a count.
        apply(6'b000000, 6'b000000, 1'b1);
        idle(20);
        apply(6'b001000, 6'b000000, 1'b0);
        idle(6);
        #1;
        reset = 1'b0;
        idle(2);
        #1;
        reset = 1'b1;
        e.val = 6'b001000;
        e.lo  = cyc + LAT_LO;
        e.hi  = cyc + LAT_HI;
        sb_q.push_back(e);
        idle(20);

        // 6. Single-cycle glitch on an otherwise zero input.
        apply(6'b000000, 6'b000000, 1'b1);
        idle(20);
        apply(6'b110110, 6'b000000, 1'b0);
        apply(6'b000000, 6'b000000, 1'b0);
        idle(100);
        check_out("glitch_reject", 6'b000000);

        idle(2);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_commits: %0d left in queue, required 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_sw_debouncer
`default_nettype wire

// File: doc/sw_debouncer.md
Name: sw_debouncer

Overview:
- Conditions the six raw board switches before they reach the RGB controller's SW input.
- Per-bit processing: synchronise into the clock domain, then debounce with a shared tick prescaler.
- Outputs a registered, glitch-free switch word plus a one-cycle change strobe.
- Sits directly upstream of rgb_controller; sw_out connects to its SW port.

Parameters:
- WIDTH, 6: number of switch bits.
- SYNC_STAGES, 2: synchroniser flop depth; minimum 2.
- TICK_DIV, 1000: clock cycles per debounce tick (10 us at 100 MHz); minimum 1.
- STABLE_TICKS, 500: consecutive disagreeing ticks needed to commit a new value (5 ms); minimum 1.

Ports:
- clock, input, 1: system clock, 100 MHz.
- reset, input, 1: asynchronous, active-low reset.
- sw_raw, input, WIDTH: asynchronous switch pins.
- sw_out, output, WIDTH: debounced switch word; drives rgb_controller SW.
- sw_changed, output, 1: one-cycle pulse in the same cycle sw_out takes a new value.

Behaviour:
- Reset (reset low, asynchronous assert):
  - All synchroniser flops, prescaler, per-bit counters, sw_out and sw_changed clear to 0.
  - Deassertion is sampled on the clock; the first active edge follows it.
- Synchroniser:
  - WIDTH-wide chain of SYNC_STAGES flops; sync = last stage.
  - No logic between stages.
- Prescaler:
  - Counter 0..TICK_DIV-1, increments every cycle and wraps to 0.
  - tick = 1 in the cycle the counter equals TICK_DIV-1.
  - TICK_DIV=1 means tick is permanently 1.
  - Width is $clog2(TICK_DIV), minimum 1 bit.
- Per-bit debounce, bit i, with count width $clog2(STABLE_TICKS+1):
  - Agree (sync[i] == sw_out[i]): count <= 0 every cycle, regardless of tick.
  - Disagree with tick=0: count holds.
  - Disagree with tick=1 and count < STABLE_TICKS-1: count <= count+1.
  - Disagree with tick=1 and count == STABLE_TICKS-1: sw_out[i] <= sync[i], count <= 0.
  - Any bounce back to agreement before commit discards progress; a later disagreement starts from 0.
- Latency:
  - From the first cycle sync[i] differs, the commit lands (STABLE_TICKS-1)*TICK_DIV+1 to STABLE_TICKS*TICK_DIV cycles later, depending on prescaler phase.
  - From sw_raw this adds SYNC_STAGES cycles.
  - sw_out is registered.
- sw_changed:
  - Registered: sw_changed <= |(sw_out_next ^ sw_out).
  - High for exactly the one cycle where the new sw_out is first visible.
  - Several bits committing on the same tick produce a single one-cycle pulse.
  - Never asserted during or immediately after reset.
- Prescaler sharing:
  - The prescaler runs free and is never restarted by input activity.
  - All bits share tick phase.
- Reset mid-operation:
  - Partial counts are lost and sw_out returns to 0.
  - A switch held at 1 re-commits after the full latency window following reset release; sw_changed pulses at that point.
- Steady input: no change to sw_out and no sw_changed; counters stay 0.

Decomposition:
- Package sw_debouncer_pkg holds:
  - default constants SW_WIDTH=6, SYNC_STAGES_DEF=2, TICK_DIV_DEF=1000, STABLE_TICKS_DEF=500;
  - function tick_cnt_width(n) returning max(1, $clog2(n)).
- Sub-module debounce_bit (ports clock, reset, sync_in, tick, stable_out).
  - Holds one bit's counter and stable flop.
  - Instantiated WIDTH times via generate.
- Synchroniser, prescaler and sw_changed logic stay in the top.

Test Plan:
All cases use TICK_DIV=4, STABLE_TICKS=3, SYNC_STAGES=2, 10 ns clock.
1. Reset: hold reset low 3 cycles with sw_raw=6'b111111 → sw_out=0 and sw_changed=0 throughout; after release, sw_out=6'b111111 within 2+9..2+12 cycles, with exactly one sw_changed pulse.
2. Clean step: from stable 0, set sw_raw=6'b000001 → sw_out[0] rises 11..14 cycles later; sw_changed high for that single cycle only; other bits remain 0.
3. Bounce: toggle sw_raw[3] every 5 cycles for 60 cycles, then hold at 1 → sw_out stays 0 during toggling; rises only 11..14 cycles after the last toggle.
4. Simultaneous bits: stable 6'b000001 → apply 6'b110000 in one cycle → sw_out goes to 6'b110000 in a single cycle; one sw_changed pulse.
5. Reset mid-count: sw_raw 0→6'b001000, assert reset 6 cycles later for 2 cycles → sw_out stays 0 through reset; after release sw_out=6'b001000 only after a full 11..14-cycle window; no early commit.
6. Glitch rejection: single-cycle pulse of sw_raw=6'b110110 on an otherwise 0 input → sw_out and sw_changed never change over 100 cycles.
